// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT fetch path: FSM states, next-address selects, vectors.
// Pure declarations; no latency; no flow control.
package rat_pkg;

  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] RST_VEC  = 10'h000;
  localparam logic [ADDR_W-1:0] INTR_VEC = 10'h3FF;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_INTR
  } fetch_st_t;

  typedef enum logic [1:0] {
    NA_INC,
    NA_BR,
    NA_RET
  } na_sel_t;

  // A return outranks a simultaneous branch.
  function automatic na_sel_t na_select(input logic ret_take, input logic br_take);
    na_sel_t sel;
    sel = NA_INC;
    if (ret_take)     sel = NA_RET;
    else if (br_take) sel = NA_BR;
    return sel;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next fetch address (return, branch, sequential) plus the PC_CUR+1 value.
// Purely combinational, zero latency; no flow control.
module pc_next_mux #(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              ret_take,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic [ADDR_W-1:0] inc,
  output logic [ADDR_W-1:0] nxt
);
  import rat_pkg::*;

  na_sel_t sel;

  // Wraps at the top of the ROM; the carry is simply dropped.
  assign inc = pc_cur + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign sel = na_select(ret_take, br_take);

  always_comb begin
    nxt = inc;
    case (sel)
      NA_RET:  nxt = ret_addr;
      NA_BR:   nxt = br_addr;
      default: nxt = inc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer in front of the 1-cycle registered program ROM.
// Two cycles per instruction, +1 on interrupt entry; STALL holds the instruction in EXEC.
module pc_fetch_ctrl #(
  parameter int                ADDR_W   = rat_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RST_VEC  = rat_pkg::RST_VEC,
  parameter logic [ADDR_W-1:0] INTR_VEC = rat_pkg::INTR_VEC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              BR_TAKE,
  input  logic [ADDR_W-1:0] BR_ADDR,
  input  logic              RET_TAKE,
  input  logic [ADDR_W-1:0] RET_ADDR,
  input  logic              INTR_REQ,
  input  logic              INTR_EN,
  output logic [ADDR_W-1:0] ADDR,
  output logic [ADDR_W-1:0] PC_CUR,
  output logic [ADDR_W-1:0] SAVE_ADDR,
  output logic              IR_VALID,
  output logic              INTR_ACK
);
  import rat_pkg::*;

  fetch_st_t         state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, cur_nxt, save_nxt;
  logic [ADDR_W-1:0] inc, nxt;
  logic              irv_nxt;

  pc_next_mux #(.ADDR_W(ADDR_W)) u_next (
    .pc_cur   (PC_CUR),
    .br_take  (BR_TAKE),
    .br_addr  (BR_ADDR),
    .ret_take (RET_TAKE),
    .ret_addr (RET_ADDR),
    .inc      (inc),
    .nxt      (nxt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_INIT;
      pc        <= RST_VEC;
      PC_CUR    <= RST_VEC;
      SAVE_ADDR <= '0;
      IR_VALID  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      PC_CUR    <= cur_nxt;
      SAVE_ADDR <= save_nxt;
      IR_VALID  <= irv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cur_nxt   = PC_CUR;
    save_nxt  = SAVE_ADDR;
    irv_nxt   = IR_VALID;
    case (state)
      ST_INIT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        state_nxt = ST_EXEC;
        cur_nxt   = pc;
        irv_nxt   = 1'b1;
      end
      ST_EXEC: begin
        if (!STALL) begin
          irv_nxt = 1'b0;
          // On interrupt the redirect target is parked in SAVE_ADDR; pc is replaced next cycle.
          if (INTR_REQ && INTR_EN) begin
            save_nxt  = nxt;
            state_nxt = ST_INTR;
          end else begin
            pc_nxt    = nxt;
            save_nxt  = inc;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_INTR: begin
        pc_nxt    = INTR_VEC;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign ADDR     = pc;
  assign INTR_ACK = (state == ST_INTR);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: an instruction-level model builds the expected
// per-cycle outputs, a negedge process compares them, and literals pin key points.
module tb_pc_fetch_ctrl;

  logic       CLK = 1'b0;
  logic       RST, STALL, BR_TAKE, RET_TAKE, INTR_REQ, INTR_EN;
  logic [9:0] BR_ADDR, RET_ADDR;
  logic [9:0] ADDR, PC_CUR, SAVE_ADDR;
  logic       IR_VALID, INTR_ACK;

  pc_fetch_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .STALL     (STALL),
    .BR_TAKE   (BR_TAKE),
    .BR_ADDR   (BR_ADDR),
    .RET_TAKE  (RET_TAKE),
    .RET_ADDR  (RET_ADDR),
    .INTR_REQ  (INTR_REQ),
    .INTR_EN   (INTR_EN),
    .ADDR      (ADDR),
    .PC_CUR    (PC_CUR),
    .SAVE_ADDR (SAVE_ADDR),
    .IR_VALID  (IR_VALID),
    .INTR_ACK  (INTR_ACK)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  logic [9:0] exp_addr, exp_cur, exp_save;
  logic       exp_irv, exp_ack;
  // Model: address of the next instruction to fetch, instruction on IR, last saved address.
  logic [9:0] m_pc, m_cur, m_save;

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("addr",      ADDR,              exp_addr);
      check("pc_cur",    PC_CUR,            exp_cur);
      check("save_addr", SAVE_ADDR,         exp_save);
      check("ir_valid",  {9'd0, IR_VALID},  {9'd0, exp_irv});
      check("intr_ack",  {9'd0, INTR_ACK},  {9'd0, exp_ack});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    STALL    = 1'b0;
    BR_TAKE  = 1'b0;
    BR_ADDR  = 10'h000;
    RET_TAKE = 1'b0;
    RET_ADDR = 10'h000;
    INTR_REQ = 1'b0;
    INTR_EN  = 1'b1;
  endtask

  task automatic set_exp(input logic [9:0] a, input logic [9:0] c, input logic v, input logic k);
    exp_addr = a;
    exp_cur  = c;
    exp_save = m_save;
    exp_irv  = v;
    exp_ack  = k;
  endtask

  // One instruction starting at its fetch cycle. irq: 0 none, 1 request+enable, 2 request masked.
  task automatic instr(input int stall, input logic stall_br, input logic br, input logic [9:0] bra,
                       input logic ret, input logic [9:0] reta, input int irq);
    logic [9:0] nxt;
    idle_in();
    STALL    = (stall > 0);
    INTR_REQ = (irq != 0);
    INTR_EN  = (irq == 1);
    set_exp(m_pc, m_cur, 1'b0, 1'b0);
    step();
    m_cur = m_pc;
    for (int s = 0; s <= stall; s++) begin
      idle_in();
      INTR_REQ = (irq != 0);
      INTR_EN  = (irq == 1);
      if (s < stall) begin
        STALL   = 1'b1;
        BR_TAKE = stall_br;
        BR_ADDR = 10'h100;
      end else begin
        BR_TAKE  = br;
        BR_ADDR  = bra;
        RET_TAKE = ret;
        RET_ADDR = reta;
      end
      set_exp(m_pc, m_cur, 1'b1, 1'b0);
      step();
    end
    nxt = ret ? reta : (br ? bra : m_cur + 10'd1);
    idle_in();
    if (irq == 1) begin
      m_save = nxt;
      set_exp(m_pc, m_cur, 1'b0, 1'b1);
      step();
      m_pc = 10'h3FF;
    end else begin
      m_pc   = nxt;
      m_save = m_cur + 10'd1;
    end
  endtask

  task automatic model_reset();
    m_pc   = 10'h000;
    m_cur  = 10'h000;
    m_save = 10'h000;
  endtask

  task automatic lit_reset(input string tag);
    check({tag, "_addr"},  ADDR,             10'h000);
    check({tag, "_cur"},   PC_CUR,           10'h000);
    check({tag, "_save"},  SAVE_ADDR,        10'h000);
    check({tag, "_irv"},   {9'd0, IR_VALID}, 10'h000);
    check({tag, "_ack"},   {9'd0, INTR_ACK}, 10'h000);
  endtask

  initial begin
    idle_in();
    model_reset();
    RST = 1'b1;
    #12;
    lit_reset("rst");
    step();
    RST = 1'b0;
    set_exp(m_pc, m_cur, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();

    check("t1_addr0", ADDR, 10'h000);
    instr(0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0);
    check("t1_addr1", ADDR, 10'h001);
    instr(0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0);
    check("t1_addr2", ADDR, 10'h002);
    instr(0, 1'b0, 1'b1, 10'h010, 1'b0, 10'h000, 0);

    instr(0, 1'b0, 1'b1, 10'h155, 1'b0, 10'h000, 0);
    check("t2_addr", ADDR, 10'h155);
    check("t2_save", SAVE_ADDR, 10'h011);

    instr(0, 1'b0, 1'b1, 10'h155, 1'b1, 10'h020, 0);
    check("t3_addr", ADDR, 10'h020);

    instr(3, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 0);
    check("t5_addr", ADDR, 10'h021);
    check("t5_cur", PC_CUR, 10'h020);

    instr(0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 2);
    check("mask_addr", ADDR, 10'h022);

    instr(0, 1'b0, 1'b1, 10'h3FE, 1'b0, 10'h000, 0);
    instr(0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1);
    check("t4_addr", ADDR, 10'h3FF);
    check("t4_save", SAVE_ADDR, 10'h3FF);
    instr(0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0);
    check("t4_wrap", ADDR, 10'h000);

    instr(0, 1'b0, 1'b1, 10'h09F, 1'b0, 10'h000, 1);
    check("irq_br_save", SAVE_ADDR, 10'h09F);
    check("irq_br_addr", ADDR, 10'h3FF);
    instr(0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h09F, 0);
    check("reti_addr", ADDR, 10'h09F);
    instr(0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0);
    check("pre_rst_addr", ADDR, 10'h0A0);

    // Enter EXEC of 0x0A0 with a pending branch, then hit reset mid-cycle.
    set_exp(m_pc, m_cur, 1'b0, 1'b0);
    step();
    chk_en = 1'b0;
    check("t6_cur", PC_CUR, 10'h0A0);
    check("t6_irv", {9'd0, IR_VALID}, 10'h001);
    BR_TAKE = 1'b1;
    BR_ADDR = 10'h155;
    #2;
    RST = 1'b1;
    #1;
    lit_reset("t6_async");
    step();
    step();
    RST = 1'b0;
    idle_in();
    model_reset();
    set_exp(m_pc, m_cur, 1'b0, 1'b0);
    chk_en = 1'b1;
    step();
    check("t6_fetch0", ADDR, 10'h000);
    instr(0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0);
    check("t6_addr1", ADDR, 10'h001);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
